bsg_cache_amo_rmw: RTL and testbench

- Parametrised atomic read-modify-write engine placed between the cache pipeline and the data/tag memory arbiter.
- Executes AMO*_W and AMO*_D opcodes as a read → ALU → masked write sequence and returns the pre-modification value.
- Generalises the fixed AMO subop set to a configurable datapath width and a configurable support level, and adds error responses.

---
 rtl/bsg_cache_amo_rmw_pkg.sv | 67 ++++++
 rtl/bsg_cache_amo_rmw_if.sv | 45 ++++
 rtl/bsg_cache_amo_alu.sv | 28 ++
 rtl/bsg_cache_amo_rmw.sv | 140 ++++++++++++++
 tb/tb_bsg_cache_amo_rmw.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bsg_cache_amo_rmw_pkg.sv
// Shared types for the AMO read-modify-write engine: opcodes, AMO subops,
// support-level masks, engine states and the opcode decode helper.
package bsg_cache_amo_rmw_pkg;

  typedef enum logic [5:0] {
    e_cache_ld        = 6'b000011,
    e_cache_sd        = 6'b001011,
    e_cache_amoswap_w = 6'b100000,
    e_cache_amoadd_w  = 6'b100001,
    e_cache_amoxor_w  = 6'b100010,
    e_cache_amoand_w  = 6'b100011,
    e_cache_amoor_w   = 6'b100100,
    e_cache_amomin_w  = 6'b100101,
    e_cache_amomax_w  = 6'b100110,
    e_cache_amominu_w = 6'b100111,
    e_cache_amomaxu_w = 6'b101000,
    e_cache_amoswap_d = 6'b110000,
    e_cache_amoadd_d  = 6'b110001,
    e_cache_amoxor_d  = 6'b110010,
    e_cache_amoand_d  = 6'b110011,
    e_cache_amoor_d   = 6'b110100,
    e_cache_amomin_d  = 6'b110101,
    e_cache_amomax_d  = 6'b110110,
    e_cache_amominu_d = 6'b110111,
    e_cache_amomaxu_d = 6'b111000
  } bsg_cache_opcode_e;

  typedef enum logic [3:0] {
    e_cache_amo_swap = 4'd0,
    e_cache_amo_add  = 4'd1,
    e_cache_amo_xor  = 4'd2,
    e_cache_amo_and  = 4'd3,
    e_cache_amo_or   = 4'd4,
    e_cache_amo_min  = 4'd5,
    e_cache_amo_max  = 4'd6,
    e_cache_amo_minu = 4'd7,
    e_cache_amo_maxu = 4'd8
  } bsg_cache_amo_subop_e;

  // One bit per 4-bit subop code so any decoded value can index the mask.
  localparam int amo_level_width_lp = 16;
  localparam logic [amo_level_width_lp-1:0] amo_support_level_none_lp       = 16'h0000;
  localparam logic [amo_level_width_lp-1:0] amo_support_level_swap_lp       = 16'h0001;
  localparam logic [amo_level_width_lp-1:0] amo_support_level_logical_lp    = 16'h001D;
  localparam logic [amo_level_width_lp-1:0] amo_support_level_arithmetic_lp = 16'h01FF;

  typedef enum logic [2:0] {
    e_amo_idle,
    e_amo_rd_req,
    e_amo_rd_wait,
    e_amo_wr_req,
    e_amo_resp
  } bsg_cache_amo_rmw_state_e;

  typedef struct packed {
    bsg_cache_amo_subop_e subop;
    logic                 is_d;
  } bsg_cache_amo_decode_s;

  function automatic bsg_cache_amo_decode_s bsg_cache_amo_decode(input bsg_cache_opcode_e op);
    bsg_cache_amo_decode_s dec;
    dec.subop = bsg_cache_amo_subop_e'(op[3:0]);
    dec.is_d  = op[4];
    return dec;
  endfunction

endpackage

// File: rtl/bsg_cache_amo_rmw_if.sv
// Request, memory and response signals of the AMO engine; slave is the
// engine's view, master the surrounding pipeline/memory view.
interface bsg_cache_amo_rmw_if
  import bsg_cache_amo_rmw_pkg::*;
#(
  parameter int data_width_p = 64,
  parameter int addr_width_p = 32,
  parameter int id_width_p   = 4
);
  logic                      v_i;
  logic                      ready_and_o;
  bsg_cache_opcode_e         opcode_i;
  logic [addr_width_p-1:0]   addr_i;
  logic [data_width_p-1:0]   data_i;
  logic [id_width_p-1:0]     id_i;

  logic                      mem_v_o;
  logic                      mem_w_o;
  logic [addr_width_p-1:0]   mem_addr_o;
  logic [data_width_p-1:0]   mem_data_o;
  logic [data_width_p/8-1:0] mem_mask_o;
  logic                      mem_ready_and_i;
  logic                      mem_v_i;
  logic [data_width_p-1:0]   mem_data_i;

  logic                      v_o;
  logic [data_width_p-1:0]   data_o;
  logic                      err_o;
  logic [id_width_p-1:0]     id_o;
  logic                      yumi_i;

  modport slave (
    input  v_i, opcode_i, addr_i, data_i, id_i,
    input  mem_ready_and_i, mem_v_i, mem_data_i, yumi_i,
    output ready_and_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_mask_o,
    output v_o, data_o, err_o, id_o
  );

  modport master (
    output v_i, opcode_i, addr_i, data_i, id_i,
    output mem_ready_and_i, mem_v_i, mem_data_i, yumi_i,
    input  ready_and_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_mask_o,
    input  v_o, data_o, err_o, id_o
  );
endinterface

// File: rtl/bsg_cache_amo_alu.sv
// Combinational AMO ALU at a given operand width; min/max keep the memory
// value on equal operands.
module bsg_cache_amo_alu
  import bsg_cache_amo_rmw_pkg::*;
#(
  parameter int width_p = 64
) (
  input  bsg_cache_amo_subop_e subop,
  input  logic [width_p-1:0]   mem_data,
  input  logic [width_p-1:0]   req_data,
  output logic [width_p-1:0]   result
);
  always_comb begin
    result = mem_data;
    case (subop)
      e_cache_amo_swap: result = req_data;
      e_cache_amo_add:  result = mem_data + req_data;
      e_cache_amo_xor:  result = mem_data ^ req_data;
      e_cache_amo_and:  result = mem_data & req_data;
      e_cache_amo_or:   result = mem_data | req_data;
      e_cache_amo_min:  result = ($signed(mem_data) <= $signed(req_data)) ? mem_data : req_data;
      e_cache_amo_max:  result = ($signed(mem_data) >= $signed(req_data)) ? mem_data : req_data;
      e_cache_amo_minu: result = (mem_data <= req_data) ? mem_data : req_data;
      e_cache_amo_maxu: result = (mem_data >= req_data) ? mem_data : req_data;
      default:          result = mem_data;
    endcase
  end
endmodule

// File: rtl/bsg_cache_amo_rmw.sv
// Atomic read-modify-write engine: read word, apply AMO, masked write-back,
// return old value. BSG_CACHE_AMO_RMW_MISALIGN_ERR_EN turns misaligned AMOs into errors.
module bsg_cache_amo_rmw
  import bsg_cache_amo_rmw_pkg::*;
#(
  parameter int data_width_p = 64,
  parameter int addr_width_p = 32,
  parameter int id_width_p   = 4,
  parameter logic [amo_level_width_lp-1:0] amo_support_level_p = amo_support_level_arithmetic_lp
) (
  input logic                clk_i,
  input logic                reset_i,
  bsg_cache_amo_rmw_if.slave bus
);
  localparam int mask_width_lp = data_width_p / 8;
  localparam int lanes_lp      = data_width_p / 32;
  localparam int lg_bytes_lp   = $clog2(mask_width_lp);
  localparam logic [addr_width_p-1:0] addr_keep_lp =
    {{(addr_width_p-lg_bytes_lp){1'b1}}, {lg_bytes_lp{1'b0}}};

  bsg_cache_amo_rmw_state_e state_r, state_n;
  bsg_cache_amo_decode_s    dec_in, dec_r;

  logic [addr_width_p-1:0]  addr_r;
  logic [data_width_p-1:0]  data_r, old_r, new_r, new_d;
  logic [id_width_p-1:0]    id_r;
  logic                     err_r;
  logic                     ready, accept, req_err, misalign, lane_sel;
  logic                     mem_v, mem_w, resp_v;
  logic [31:0]              mem_lane, new_w;
  logic [mask_width_lp-1:0] mask_w;

  assign dec_in = bsg_cache_amo_decode(bus.opcode_i);

`ifdef BSG_CACHE_AMO_RMW_MISALIGN_ERR_EN
  assign misalign = dec_in.is_d ? (bus.addr_i[2:0] != 3'b000) : (bus.addr_i[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign req_err = ~bus.opcode_i[5]
                 | ~amo_support_level_p[dec_in.subop]
                 | (dec_in.is_d & (data_width_p == 32))
                 | misalign;

  assign ready  = (state_r == e_amo_idle) & ~reset_i;
  assign accept = bus.v_i & ready;

  assign lane_sel = (data_width_p == 64) ? addr_r[2] : 1'b0;
  assign mem_lane = lane_sel ? bus.mem_data_i[data_width_p-1 -: 32] : bus.mem_data_i[31:0];

  bsg_cache_amo_alu #(.width_p(32)) alu_w (
    .subop    (dec_r.subop),
    .mem_data (mem_lane),
    .req_data (data_r[31:0]),
    .result   (new_w)
  );

  bsg_cache_amo_alu #(.width_p(data_width_p)) alu_d (
    .subop    (dec_r.subop),
    .mem_data (bus.mem_data_i),
    .req_data (data_r),
    .result   (new_d)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= e_amo_idle;
      dec_r   <= '0;
      addr_r  <= '0;
      data_r  <= '0;
      id_r    <= '0;
      err_r   <= 1'b0;
      old_r   <= '0;
      new_r   <= '0;
    end else begin
      state_r <= state_n;
      if (accept) begin
        dec_r  <= dec_in;
        addr_r <= bus.addr_i;
        data_r <= bus.data_i;
        id_r   <= bus.id_i;
        err_r  <= req_err;
        old_r  <= '0;
      end
      // Old and new values are both captured here so WR_REQ/RESP see stable registers.
      if ((state_r == e_amo_rd_wait) && bus.mem_v_i) begin
        old_r <= dec_r.is_d ? bus.mem_data_i : data_width_p'(signed'(mem_lane));
        new_r <= dec_r.is_d ? new_d : {lanes_lp{new_w}};
      end
    end
  end

  always_comb begin
    state_n = state_r;
    mem_v   = 1'b0;
    mem_w   = 1'b0;
    resp_v  = 1'b0;
    case (state_r)
      e_amo_idle: begin
        if (accept) state_n = req_err ? e_amo_resp : e_amo_rd_req;
      end
      e_amo_rd_req: begin
        mem_v = 1'b1;
        if (bus.mem_ready_and_i) state_n = e_amo_rd_wait;
      end
      e_amo_rd_wait: begin
        if (bus.mem_v_i) state_n = e_amo_wr_req;
      end
      e_amo_wr_req: begin
        mem_v = 1'b1;
        mem_w = 1'b1;
        if (bus.mem_ready_and_i) state_n = e_amo_resp;
      end
      e_amo_resp: begin
        resp_v = 1'b1;
        if (bus.yumi_i) state_n = e_amo_idle;
      end
      default: state_n = e_amo_idle;
    endcase
  end

  always_comb begin
    mask_w = '0;
    if (lane_sel) mask_w[mask_width_lp-1 -: 4] = '1;
    else          mask_w[3:0] = '1;
  end

  assign bus.ready_and_o = ready;
  assign bus.mem_v_o     = mem_v;
  assign bus.mem_w_o     = mem_w;
  assign bus.mem_addr_o  = mem_v ? (addr_r & addr_keep_lp) : '0;
  assign bus.mem_data_o  = mem_w ? new_r : '0;
  assign bus.mem_mask_o  = mem_w ? (dec_r.is_d ? '1 : mask_w) : '0;
  assign bus.v_o         = resp_v;
  assign bus.data_o      = resp_v ? old_r : '0;
  assign bus.err_o       = resp_v & err_r;
  assign bus.id_o        = resp_v ? id_r : '0;

endmodule

// File: tb/tb_bsg_cache_amo_rmw.sv
// Directed self-checking bench for bsg_cache_amo_rmw (64-bit full-support
// instance plus a logical-only instance for the unsupported-subop path).
module tb_bsg_cache_amo_rmw;
  import bsg_cache_amo_rmw_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bsg_cache_amo_rmw_if #(.data_width_p(64), .addr_width_p(32), .id_width_p(4)) if0 ();
  bsg_cache_amo_rmw_if #(.data_width_p(64), .addr_width_p(32), .id_width_p(4)) if1 ();

  bsg_cache_amo_rmw #(
    .data_width_p(64), .addr_width_p(32), .id_width_p(4),
    .amo_support_level_p(amo_support_level_arithmetic_lp)
  ) dut0 (.clk_i(clk), .reset_i(rst), .bus(if0));

  bsg_cache_amo_rmw #(
    .data_width_p(64), .addr_width_p(32), .id_width_p(4),
    .amo_support_level_p(amo_support_level_logical_lp)
  ) dut1 (.clk_i(clk), .reset_i(rst), .bus(if1));

  assign if1.mem_ready_and_i = 1'b1;
  assign if1.mem_v_i         = 1'b0;
  assign if1.mem_data_i      = '0;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory responder controls (written by the test only)
  logic [63:0] mem_init = '0;
  int          init_seq = 0;
  int          stall_cycles = 0;
  bit          hold_read = 1'b0;
  int          stale_seq = 0;
  // Responder state (written by the responder only)
  logic [63:0] mem_word;
  int          init_seen = 0, stale_seen = 0, stall_ctr = 0;
  bit          pending_read = 1'b0;
  int          n_rd = 0, n_wr = 0;
  logic [63:0] wr_data;
  logic [7:0]  wr_mask;
  logic [31:0] wr_addr, rd_addr;
  int          n_mem1 = 0;

  always @(negedge clk) begin
    if (init_seq != init_seen) begin
      init_seen = init_seq;
      mem_word  = mem_init;
    end
    if0.mem_v_i         = 1'b0;
    if0.mem_ready_and_i = 1'b0;
    if (stale_seq != stale_seen) begin
      stale_seen     = stale_seq;
      if0.mem_v_i    = 1'b1;
      if0.mem_data_i = 64'hDEAD_BEEF_DEAD_BEEF;
    end else if (pending_read) begin
      pending_read   = 1'b0;
      if0.mem_v_i    = 1'b1;
      if0.mem_data_i = mem_word;
    end
    if (if0.mem_v_o && !if0.mem_w_o && stall_ctr < stall_cycles) begin
      stall_ctr++;
    end else if (if0.mem_v_o) begin
      stall_ctr = 0;
      if0.mem_ready_and_i = 1'b1;
      if (if0.mem_w_o) begin
        n_wr++;
        wr_data = if0.mem_data_o;
        wr_mask = if0.mem_mask_o;
        wr_addr = if0.mem_addr_o;
        for (int b = 0; b < 8; b++)
          if (wr_mask[b]) mem_word[8*b +: 8] = wr_data[8*b +: 8];
      end else begin
        n_rd++;
        rd_addr = if0.mem_addr_o;
        if (!hold_read) pending_read = 1'b1;
      end
    end else begin
      stall_ctr = 0;
    end
  end

  always @(posedge clk) if (if1.mem_v_o) n_mem1++;

  task automatic send(input bsg_cache_opcode_e op, input logic [31:0] a,
                      input logic [63:0] d, input logic [3:0] id);
    @(negedge clk);
    check_eq("ready_before_req", if0.ready_and_o, 1'b1);
    if0.v_i = 1'b1; if0.opcode_i = op; if0.addr_i = a; if0.data_i = d; if0.id_i = id;
    @(posedge clk); #1;
    if0.v_i = 1'b0;
  endtask

  task automatic get_resp(input int yumi_delay, output logic [63:0] d, output logic e,
                          output logic [3:0] id, output int lat);
    lat = 1;
    while (!if0.v_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    d = if0.data_o; e = if0.err_o; id = if0.id_o;
    for (int i = 0; i < yumi_delay; i++) begin
      @(posedge clk); #1;
      check_eq("resp_hold_data", if0.data_o, d);
      check_eq("resp_hold_ready", if0.ready_and_o, 1'b0);
    end
    @(negedge clk); if0.yumi_i = 1'b1;
    @(posedge clk); #1; if0.yumi_i = 1'b0;
  endtask

  task automatic do_amo(input string tag, input bsg_cache_opcode_e op, input logic [31:0] a,
                        input logic [63:0] d, input logic [63:0] mem, input logic [63:0] exp_wdata,
                        input logic [7:0] exp_mask, input logic [63:0] exp_old, input logic [3:0] id);
    int rd0, wr0, lat;
    logic [63:0] rd; logic e; logic [3:0] rid;
    rd0 = n_rd; wr0 = n_wr;
    mem_init = mem; init_seq++;
    send(op, a, d, id);
    get_resp(0, rd, e, rid, lat);
    check_eq({tag, "_latency"}, 64'(lat), 64'd4);
    check_eq({tag, "_err"}, e, 1'b0);
    check_eq({tag, "_data"}, rd, exp_old);
    check_eq({tag, "_id"}, rid, id);
    check_eq({tag, "_reads"}, 64'(n_rd - rd0), 64'd1);
    check_eq({tag, "_writes"}, 64'(n_wr - wr0), 64'd1);
    check_eq({tag, "_rd_addr"}, rd_addr, a & 32'hFFFF_FFF8);
    check_eq({tag, "_wr_addr"}, wr_addr, a & 32'hFFFF_FFF8);
    check_eq({tag, "_wr_data"}, wr_data, exp_wdata);
    check_eq({tag, "_wr_mask"}, wr_mask, exp_mask);
  endtask

  task automatic do_err(input string tag, input bsg_cache_opcode_e op, input logic [31:0] a,
                        input logic [3:0] id, input bit chk_data);
    int rd0, wr0, lat;
    logic [63:0] rd; logic e; logic [3:0] rid;
    rd0 = n_rd; wr0 = n_wr;
    send(op, a, 64'h1234, id);
    get_resp(0, rd, e, rid, lat);
    check_eq({tag, "_latency"}, 64'(lat), 64'd1);
    check_eq({tag, "_err"}, e, 1'b1);
    check_eq({tag, "_id"}, rid, id);
    check_eq({tag, "_traffic"}, 64'(n_rd - rd0 + n_wr - wr0), 64'd0);
    if (chk_data) check_eq({tag, "_data"}, rd, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0, rd0, lat;
    logic [63:0] rd; logic e; logic [3:0] rid;

    if0.v_i = 1'b0; if0.opcode_i = e_cache_ld; if0.addr_i = '0; if0.data_i = '0;
    if0.id_i = '0; if0.yumi_i = 1'b0;
    if1.v_i = 1'b0; if1.opcode_i = e_cache_ld; if1.addr_i = '0; if1.data_i = '0;
    if1.id_i = '0; if1.yumi_i = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("rst_ready", if0.ready_and_o, 1'b0);
    check_eq("rst_mem_v", if0.mem_v_o, 1'b0);
    check_eq("rst_v", if0.v_o, 1'b0);
    check_eq("rst_data", if0.data_o, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("post_rst_ready", if0.ready_and_o, 1'b1);

    do_amo("addw_hi", e_cache_amoadd_w, 32'h104, 64'h1, 64'hFFFFFFFF_00000005,
           64'h0, 8'hF0, 64'hFFFFFFFF_FFFFFFFF, 4'h1);
    do_amo("addw_lo", e_cache_amoadd_w, 32'h100, 64'h1, 64'hFFFFFFFF_00000005,
           64'h00000006_00000006, 8'h0F, 64'h5, 4'h2);
    do_amo("mind", e_cache_amomin_d, 32'h100, 64'h1, 64'h80000000_00000000,
           64'h80000000_00000000, 8'hFF, 64'h80000000_00000000, 4'h3);
    do_amo("minud", e_cache_amominu_d, 32'h100, 64'h1, 64'h80000000_00000000,
           64'h1, 8'hFF, 64'h80000000_00000000, 4'h4);
    do_amo("maxw", e_cache_amomax_w, 32'h104, 64'h7FFFFFFF, 64'h80000000_00000001,
           64'h7FFFFFFF_7FFFFFFF, 8'hF0, 64'hFFFFFFFF_80000000, 4'h5);
    do_amo("maxuw", e_cache_amomaxu_w, 32'h104, 64'h7FFFFFFF, 64'h80000000_00000001,
           64'h80000000_80000000, 8'hF0, 64'hFFFFFFFF_80000000, 4'h6);
    do_amo("addd_wrap", e_cache_amoadd_d, 32'h10, 64'h2, 64'hFFFFFFFF_FFFFFFFF,
           64'h1, 8'hFF, 64'hFFFFFFFF_FFFFFFFF, 4'h7);
    do_amo("andw", e_cache_amoand_w, 32'h0, 64'h0000FFFF, 64'h12345678_9ABCDEF0,
           64'h0000DEF0_0000DEF0, 8'h0F, 64'hFFFFFFFF_9ABCDEF0, 4'h8);
    do_amo("ord", e_cache_amoor_d, 32'h8, 64'hF0, 64'h0000000F_0000000F,
           64'h0000000F_000000FF, 8'hFF, 64'h0000000F_0000000F, 4'h9);
    do_amo("swapd", e_cache_amoswap_d, 32'h18, 64'hCAFEBABE_12345678, 64'h1,
           64'hCAFEBABE_12345678, 8'hFF, 64'h1, 4'hA);

`ifdef BSG_CACHE_AMO_RMW_MISALIGN_ERR_EN
    do_err("swapw_misalign", e_cache_amoswap_w, 32'h102, 4'hB, 1'b1);
`else
    do_amo("swapw_misalign", e_cache_amoswap_w, 32'h102, 64'hAAAAAAAA, 64'h11111111_22222222,
           64'hAAAAAAAA_AAAAAAAA, 8'h0F, 64'h22222222, 4'hB);
`endif
    do_err("not_amo", e_cache_ld, 32'h100, 4'hC, 1'b0);

    // Backpressure on the read request and on the response
    stall_cycles = 5;
    rd0 = n_rd; wr0 = n_wr;
    mem_init = 64'h0F0F0F0F_0F0F0F0F; init_seq++;
    send(e_cache_amoxor_d, 32'h308, 64'hFFFF0000_FFFF0000, 4'hD);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_mem_v", if0.mem_v_o, 1'b1);
      check_eq("bp_mem_w", if0.mem_w_o, 1'b0);
      check_eq("bp_mem_addr", if0.mem_addr_o, 32'h308);
      check_eq("bp_ready", if0.ready_and_o, 1'b0);
      @(posedge clk); #1;
    end
    get_resp(3, rd, e, rid, lat);
    stall_cycles = 0;
    check_eq("bp_data", rd, 64'h0F0F0F0F_0F0F0F0F);
    check_eq("bp_err", e, 1'b0);
    check_eq("bp_reads", 64'(n_rd - rd0), 64'd1);
    check_eq("bp_writes", 64'(n_wr - wr0), 64'd1);
    check_eq("bp_wr_data", wr_data, 64'hF0F00F0F_F0F00F0F);

    // Reset while waiting for read data, then a stale read beat
    hold_read = 1'b1;
    wr0 = n_wr;
    send(e_cache_amoadd_d, 32'h200, 64'h1, 4'h5);
    @(posedge clk); #1;
    check_eq("rw_mem_v_in_wait", if0.mem_v_o, 1'b0);
    rst = 1'b1;
    #1;
    check_eq("rw_rst_ready", if0.ready_and_o, 1'b0);
    check_eq("rw_rst_mem_v", if0.mem_v_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    hold_read = 1'b0;
    stale_seq++;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq("rw_no_resp", if0.v_o, 1'b0);
      check_eq("rw_no_mem", if0.mem_v_o, 1'b0);
    end
    check_eq("rw_no_write", 64'(n_wr - wr0), 64'd0);
    do_amo("after_rst", e_cache_amoxor_w, 32'h204, 64'h0000FFFF, 64'h00FF00FF_11111111,
           64'h00FFFF00_00FFFF00, 8'hF0, 64'h00000000_00FF00FF, 4'hE);

    // Logical-only instance rejects an arithmetic subop
    @(negedge clk);
    check_eq("lg_ready", if1.ready_and_o, 1'b1);
    if1.v_i = 1'b1; if1.opcode_i = e_cache_amoadd_d; if1.addr_i = 32'h40; if1.id_i = 4'h3;
    @(posedge clk); #1;
    if1.v_i = 1'b0;
    check_eq("lg_v", if1.v_o, 1'b1);
    check_eq("lg_err", if1.err_o, 1'b1);
    check_eq("lg_id", if1.id_o, 4'h3);
    @(negedge clk); if1.yumi_i = 1'b1;
    @(posedge clk); #1; if1.yumi_i = 1'b0;
    check_eq("lg_back_idle", if1.ready_and_o, 1'b1);
    check_eq("lg_no_mem", 64'(n_mem1), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
